// File: rtl/vmx_chain_feeder_if.sv
// Command, input-word and PE-chain feed signals of vmx_chain_feeder.
// master = command/word producer side, slave = the feeder itself.
interface vmx_chain_feeder_if #(
    parameter int unsigned VECTOR_BITLEN = 16,
    parameter int unsigned LEN_BITLEN    = 16
);
    // Command channel
    logic                     cmd_valid;
    logic                     cmd_ready;
    logic                     cmd_op;
    logic [LEN_BITLEN-1:0]    cmd_len;
    logic                     cmd_simd;

    // Input word channel
    logic [VECTOR_BITLEN-1:0] s_data;
    logic                     s_valid;
    logic                     s_ready;

    // Feed into the first PE plus status
    logic                     simd_mode;
    logic [7:0]               is_weight;
    logic [VECTOR_BITLEN-1:0] data;
    logic                     data_valid;
    logic                     busy;
    logic                     done;

    modport master (
        output cmd_valid, cmd_op, cmd_len, cmd_simd, s_data, s_valid,
        input  cmd_ready, s_ready, simd_mode, is_weight, data, data_valid, busy, done
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_len, cmd_simd, s_data, s_valid,
        output cmd_ready, s_ready, simd_mode, is_weight, data, data_valid, busy, done
    );
endinterface

// File: rtl/vmx_chain_feeder.sv
// Feeds weights (tagged 8'h80+k for PE k) or vector words into a PE chain,
// then flushes N_PE bubble cycles so the last token reaches the chain end.
module vmx_chain_feeder #(
    parameter int unsigned VECTOR_BITLEN = 16,
    parameter int unsigned N_PE          = 8,
    parameter int unsigned LEN_BITLEN    = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    vmx_chain_feeder_if.slave   bus
);

    localparam int unsigned IDX_W = (N_PE > 1) ? $clog2(N_PE) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_PE - 1);
    localparam logic [7:0] TOK_WEIGHT = 8'h80;
    localparam logic [7:0] TOK_BUBBLE = 8'h00;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_STREAM,
        ST_FLUSH
    } state_t;

    state_t                   state_q, state_d;
    logic [IDX_W-1:0]         k_q, k_d;
    logic [LEN_BITLEN-1:0]    len_q, len_d;
    logic [IDX_W-1:0]         flush_q, flush_d;

    logic                     cmd_ready_q, cmd_ready_d;
    logic                     s_ready_q, s_ready_d;
    logic                     busy_q, busy_d;
    logic                     done_q, done_d;
    logic                     simd_mode_q, simd_mode_d;
    logic [7:0]               is_weight_q, is_weight_d;
    logic [VECTOR_BITLEN-1:0] data_q, data_d;
    logic                     data_valid_q, data_valid_d;

    logic                     cmd_acc;
    logic                     s_acc;

    // Handshakes qualify against the registered ready flags the producer sees
    assign cmd_acc = bus.cmd_valid && cmd_ready_q;
    assign s_acc   = bus.s_valid && s_ready_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            k_q          <= '0;
            len_q        <= '0;
            flush_q      <= '0;
            cmd_ready_q  <= 1'b1;
            s_ready_q    <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            simd_mode_q  <= 1'b0;
            is_weight_q  <= TOK_BUBBLE;
            data_q       <= '0;
            data_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            k_q          <= k_d;
            len_q        <= len_d;
            flush_q      <= flush_d;
            cmd_ready_q  <= cmd_ready_d;
            s_ready_q    <= s_ready_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            simd_mode_q  <= simd_mode_d;
            is_weight_q  <= is_weight_d;
            data_q       <= data_d;
            data_valid_q <= data_valid_d;
        end
    end

    // Next state, counters and the next word presented to the chain
    always_comb begin
        state_d      = state_q;
        k_d          = k_q;
        len_d        = len_q;
        flush_d      = flush_q;
        simd_mode_d  = simd_mode_q;
        is_weight_d  = TOK_BUBBLE;
        data_d       = '0;
        data_valid_d = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (cmd_acc) begin
                    simd_mode_d = bus.cmd_simd;
                    k_d         = '0;
                    flush_d     = '0;
                    if (!bus.cmd_op) begin
                        state_d = ST_LOAD;
                    end else if (bus.cmd_len != '0) begin
                        state_d = ST_STREAM;
                        len_d   = bus.cmd_len;
                    end else begin
                        state_d = ST_FLUSH;
                    end
                end
            end

            ST_LOAD: begin
                if (s_acc) begin
                    is_weight_d = TOK_WEIGHT + 8'(k_q);
                    data_d      = bus.s_data;
                    if (k_q == LAST_IDX) begin
                        state_d = ST_FLUSH;
                        k_d     = '0;
                        flush_d = '0;
                    end else begin
                        k_d = k_q + 1'b1;
                    end
                end
            end

            ST_STREAM: begin
                if (s_acc) begin
                    data_d       = bus.s_data;
                    data_valid_d = 1'b1;
                    len_d        = len_q - 1'b1;
                    if (len_q == LEN_BITLEN'(1)) begin
                        state_d = ST_FLUSH;
                        flush_d = '0;
                    end
                end
            end

            ST_FLUSH: begin
                if (flush_q == LAST_IDX) begin
                    state_d = ST_IDLE;
                    flush_d = '0;
                end else begin
                    flush_d = flush_q + 1'b1;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Status flags are registered views of the state being entered
        cmd_ready_d = (state_d == ST_IDLE);
        s_ready_d   = (state_d == ST_LOAD) || (state_d == ST_STREAM);
        busy_d      = (state_d != ST_IDLE);
        done_d      = (state_d == ST_FLUSH) && (flush_d == LAST_IDX);
    end

    assign bus.cmd_ready  = cmd_ready_q;
    assign bus.s_ready    = s_ready_q;
    assign bus.busy       = busy_q;
    assign bus.done       = done_q;
    assign bus.simd_mode  = simd_mode_q;
    assign bus.is_weight  = is_weight_q;
    assign bus.data       = data_q;
    assign bus.data_valid = data_valid_q;

endmodule

// File: tb/tb_vmx_chain_feeder.sv
// Directed bench for vmx_chain_feeder (N_PE=4): command-level model compared
// every cycle, plus literal checks on token order, stream data and PE weights.
module tb_vmx_chain_feeder;

    localparam int unsigned N_PE = 4;
    localparam int unsigned VB   = 16;
    localparam int unsigned LB   = 16;

    localparam int P_IDLE   = 0;
    localparam int P_LOAD   = 1;
    localparam int P_STREAM = 2;
    localparam int P_FLUSH  = 3;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    vmx_chain_feeder_if #(.VECTOR_BITLEN(VB), .LEN_BITLEN(LB)) bus ();

    vmx_chain_feeder #(.VECTOR_BITLEN(VB), .N_PE(N_PE), .LEN_BITLEN(LB)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_err    = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s t=%0t actual=%0h expected=%0h", nm, $time, act, exp);
        end
    endtask

    // ---------------- command-level model ----------------
    int          m_phase;
    int          m_k;
    int          m_left;
    int          m_flush;
    logic        m_simd;
    logic [7:0]  m_w;
    logic [15:0] m_data;
    logic        m_dv;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_phase = P_IDLE; m_k = 0; m_left = 0; m_flush = 0;
            m_simd = 1'b0; m_w = 8'h00; m_data = 16'h0; m_dv = 1'b0;
        end else begin
            m_w = 8'h00; m_data = 16'h0; m_dv = 1'b0;
            case (m_phase)
                P_IDLE: if (bus.cmd_valid) begin
                    m_simd = bus.cmd_simd;
                    if (!bus.cmd_op) begin
                        m_phase = P_LOAD; m_k = 0;
                    end else if (int'(bus.cmd_len) > 0) begin
                        m_phase = P_STREAM; m_left = int'(bus.cmd_len);
                    end else begin
                        m_phase = P_FLUSH; m_flush = N_PE;
                    end
                end
                P_LOAD: if (bus.s_valid) begin
                    m_w = 8'(128 + m_k); m_data = bus.s_data;
                    m_k = m_k + 1;
                    if (m_k == N_PE) begin m_phase = P_FLUSH; m_flush = N_PE; end
                end
                P_STREAM: if (bus.s_valid) begin
                    m_data = bus.s_data; m_dv = 1'b1;
                    m_left = m_left - 1;
                    if (m_left == 0) begin m_phase = P_FLUSH; m_flush = N_PE; end
                end
                default: begin
                    m_flush = m_flush - 1;
                    if (m_flush == 0) m_phase = P_IDLE;
                end
            endcase
        end
    end

    // ---------------- per-cycle compare + observers ----------------
    logic [7:0]  wlog[$];
    logic [15:0] dlog[$];
    int          done_cnt = 0;
    int          sr_cnt   = 0;
    int          cyc      = 0;
    int          acc_cyc  = -1;
    int          done_cyc = -1;
    logic [7:0]  pe_tok[N_PE];
    logic [15:0] pe_dat[N_PE];
    logic [15:0] pe_w[N_PE];

    initial begin
        for (int i = 0; i < N_PE; i++) begin
            pe_tok[i] = 8'h00; pe_dat[i] = 16'h0; pe_w[i] = 16'h0;
        end
    end

    always @(negedge clk) begin
        check("cmd_ready",  32'(bus.cmd_ready),  32'(m_phase == P_IDLE));
        check("s_ready",    32'(bus.s_ready),    32'(m_phase == P_LOAD || m_phase == P_STREAM));
        check("busy",       32'(bus.busy),       32'(m_phase != P_IDLE));
        check("done",       32'(bus.done),       32'(m_phase == P_FLUSH && m_flush == 1));
        check("simd_mode",  32'(bus.simd_mode),  32'(m_simd));
        check("is_weight",  32'(bus.is_weight),  32'(m_w));
        check("data",       32'(bus.data),       32'(m_data));
        check("data_valid", 32'(bus.data_valid), 32'(m_dv));

        cyc++;
        wlog.push_back(bus.is_weight);
        if (bus.data_valid) dlog.push_back(bus.data);
        if (bus.done) begin done_cnt++; done_cyc = cyc; end
        if (bus.s_ready) sr_cnt++;
        if (bus.cmd_valid && bus.cmd_ready) acc_cyc = cyc;

        // Simple PE chain: token and data hop one PE per cycle
        for (int i = N_PE - 1; i > 0; i--) begin
            pe_tok[i] = pe_tok[i-1]; pe_dat[i] = pe_dat[i-1];
        end
        pe_tok[0] = bus.is_weight; pe_dat[0] = bus.data;
        for (int i = 0; i < N_PE; i++)
            if (pe_tok[i] == 8'(128 + i)) pe_w[i] = pe_dat[i];
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic send_cmd(input logic op, input int len, input logic simd);
        int w;
        bus.cmd_valid = 1'b1; bus.cmd_op = op; bus.cmd_len = LB'(len); bus.cmd_simd = simd;
        w = 0;
        while (!bus.cmd_ready && w < 100) begin tick(); w++; end
        if (w >= 100) check("cmd_timeout", 32'd1, 32'd0);
        tick();
        bus.cmd_valid = 1'b0;
    endtask

    task automatic send_word(input logic [15:0] d);
        int w;
        bus.s_valid = 1'b1; bus.s_data = d;
        w = 0;
        while (!bus.s_ready && w < 100) begin tick(); w++; end
        if (w >= 100) check("word_timeout", 32'd1, 32'd0);
        tick();
        bus.s_valid = 1'b0; bus.s_data = 16'h0;
    endtask

    task automatic wait_idle();
        int w;
        w = 0;
        while (bus.busy && w < 100) begin tick(); w++; end
        if (w >= 100) check("idle_timeout", 32'd1, 32'd0);
        tick(2);
    endtask

    task automatic check_tokens(input string nm, input logic [7:0] exp[$]);
        int s;
        s = -1;
        for (int i = 0; i < wlog.size(); i++)
            if (s < 0 && wlog[i] == 8'h80) s = i;
        check({nm, "_found"}, 32'(s >= 0 && s + exp.size() <= wlog.size()), 32'd1);
        if (s >= 0 && s + exp.size() <= wlog.size())
            for (int i = 0; i < exp.size(); i++)
                check(nm, 32'(wlog[s+i]), 32'(exp[i]));
    endtask

    // ---------------- directed sequence ----------------
    logic [7:0] exp_tok[$];

    initial begin
        rst_n = 1'b0;
        bus.cmd_valid = 1'b0; bus.cmd_op = 1'b0; bus.cmd_len = '0; bus.cmd_simd = 1'b0;
        bus.s_valid = 1'b0; bus.s_data = '0;
        tick(3);
        check("rst_is_weight", 32'(bus.is_weight), 32'h0);
        check("rst_busy",      32'(bus.busy),      32'h0);
        check("rst_s_ready",   32'(bus.s_ready),   32'h0);
        rst_n = 1'b1;
        tick(2);
        check("rst_cmd_ready", 32'(bus.cmd_ready), 32'h1);

        // Weight load, back-to-back
        wlog.delete();
        send_cmd(1'b0, 0, 1'b0);
        send_word(16'h0011); send_word(16'h0022); send_word(16'h0033); send_word(16'h0044);
        wait_idle();
        exp_tok = '{8'h80, 8'h81, 8'h82, 8'h83, 8'h00, 8'h00, 8'h00, 8'h00};
        check_tokens("load_tok", exp_tok);
        check("load_done_cnt", 32'(done_cnt), 32'd1);
        check("pe0_w", 32'(pe_w[0]), 32'h11);
        check("pe1_w", 32'(pe_w[1]), 32'h22);
        check("pe2_w", 32'(pe_w[2]), 32'h33);
        check("pe3_w", 32'(pe_w[3]), 32'h44);

        // Vector stream, SIMD
        dlog.delete();
        send_cmd(1'b1, 3, 1'b1);
        send_word(16'h0102); send_word(16'h0304); send_word(16'h0506);
        wait_idle();
        check("stream_cnt", 32'(dlog.size()), 32'd3);
        if (dlog.size() == 3) begin
            check("stream_w0", 32'(dlog[0]), 32'h0102);
            check("stream_w1", 32'(dlog[1]), 32'h0304);
            check("stream_w2", 32'(dlog[2]), 32'h0506);
        end
        check("stream_simd", 32'(bus.simd_mode), 32'h1);
        check("stream_done_cnt", 32'(done_cnt), 32'd2);

        // Load with a two-cycle stall between words 1 and 2
        wlog.delete();
        send_cmd(1'b0, 0, 1'b0);
        send_word(16'h00A1); send_word(16'h00A2);
        tick(2);
        send_word(16'h00A3); send_word(16'h00A4);
        wait_idle();
        exp_tok = '{8'h80, 8'h81, 8'h00, 8'h00, 8'h82, 8'h83, 8'h00, 8'h00, 8'h00, 8'h00};
        check_tokens("stall_tok", exp_tok);
        check("stall_pe2_w", 32'(pe_w[2]), 32'hA3);
        check("stall_done_cnt", 32'(done_cnt), 32'd3);

        // Zero-length stream
        sr_cnt = 0;
        send_cmd(1'b1, 0, 1'b0);
        wait_idle();
        check("zero_s_ready_cycles", 32'(sr_cnt), 32'd0);
        check("zero_done_cnt", 32'(done_cnt), 32'd4);
        check("zero_simd", 32'(bus.simd_mode), 32'h0);

        // Reset after one of three stream words
        dlog.delete();
        send_cmd(1'b1, 3, 1'b1);
        send_word(16'h0BAD);
        rst_n = 1'b0;
        #1;
        check("mid_rst_busy",  32'(bus.busy),       32'h0);
        check("mid_rst_dv",    32'(bus.data_valid), 32'h0);
        check("mid_rst_data",  32'(bus.data),       32'h0);
        check("mid_rst_simd",  32'(bus.simd_mode),  32'h0);
        tick(2);
        rst_n = 1'b1;
        tick();
        check("mid_rst_no_done", 32'(done_cnt), 32'd4);
        send_cmd(1'b1, 1, 1'b0);
        send_word(16'h0777);
        wait_idle();
        check("post_rst_words", 32'(dlog.size()), 32'd1);
        if (dlog.size() == 1) check("post_rst_w0", 32'(dlog[0]), 32'h0777);
        check("post_rst_done_cnt", 32'(done_cnt), 32'd5);

        // Command held during a stream waits until the feeder is idle
        send_cmd(1'b1, 2, 1'b0);
        acc_cyc = -1; done_cyc = -1;
        bus.cmd_valid = 1'b1; bus.cmd_op = 1'b1; bus.cmd_len = '0; bus.cmd_simd = 1'b0;
        send_word(16'h1111); send_word(16'h2222);
        for (int w = 0; w < 100 && !bus.cmd_ready; w++) tick();
        tick();
        bus.cmd_valid = 1'b0;
        check("bp_accept_after_done", 32'(acc_cyc - done_cyc), 32'd1);
        check("bp_done_seen", 32'(done_cyc > 0), 32'd1);
        tick();
        wait_idle();
        check("bp_done_cnt", 32'(done_cnt), 32'd7);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog t=%0t actual=running expected=finished", $time);
        $fatal(1, "watchdog");
    end

endmodule
